braille_reader_ctrl: RTL and testbench

BRAILLE_READER_CTRL -- requirements
Module: braille_reader_ctrl

---
 rtl/braille_reader_ctrl.sv | 150 +++++++++++++++
 tb/tb_braille_reader_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/braille_reader_ctrl.sv
// Braille reader controller: buffers up to DEPTH six-dot cells, then plays
// them back one at a time on a debounced "next" button, with an all-off gap
// between characters so the reader feels each new cell as a distinct event.
module braille_reader_ctrl #(
    parameter int DEPTH        = 16,
    parameter int DEB_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 256
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    wr_valid,
    input  logic [5:0]                              wr_data,
    output logic                                    wr_ready,
    input  logic                                    start,
    input  logic                                    clear,
    input  logic                                    next_btn,
    output logic [5:0]                              dots,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] idx,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0]   count,
    output logic                                    busy,
    output logic                                    done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK, DONE} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   idx_d;
    logic [CW-1:0]   count_d;
    logic [GW-1:0]   gap, gap_d;
    logic [5:0]      dots_d;
    logic [5:0]      mem [DEPTH];

    logic            sync1, sync2, deb_level, deb_prev;
    logic [DW-1:0]   deb_cnt;
    logic            next_evt;
    logic            we;
    logic            last;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= next_btn;
            sync2 <= sync1;
        end
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            deb_prev  <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            if (sync2 != deb_level) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign next_evt = deb_level & ~deb_prev;

    assign wr_ready = (state == IDLE) && (count < CW'(DEPTH));
    assign we       = wr_valid && wr_ready && !clear;
    assign last     = ({1'b0, idx} == (count - CW'(1)));
    assign busy     = (state == SHOW) || (state == BLANK);
    assign done     = (state == DONE);

    // Character buffer; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we)
            mem[count[AW-1:0]] <= wr_data;
    end

    // Next-state logic; dots is computed from the next state so the pattern
    // is already valid in the first cycle of SHOW.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        gap_d   = gap;
        count_d = count;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            gap_d   = '0;
            count_d = '0;
        end else begin
            if (we)
                count_d = count + CW'(1);
            unique case (state)
                IDLE: if (start && count != '0) begin
                    state_d = SHOW;
                    idx_d   = '0;
                end
                SHOW: if (next_evt) begin
                    state_d = BLANK;
                    gap_d   = GW'(BLANK_CYCLES);
                end
                BLANK: begin
                    gap_d = gap - GW'(1);
                    if (gap == GW'(1)) begin
                        if (last) begin
                            state_d = DONE;
                        end else begin
                            state_d = SHOW;
                            idx_d   = idx + AW'(1);
                        end
                    end
                end
                DONE: if (start) begin
                    state_d = SHOW;
                    idx_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        dots_d = (state_d == SHOW) ? mem[idx_d] : 6'd0;
    end

    // Playback state, counters and registered actuator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            gap   <= '0;
            count <= '0;
            dots  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            gap   <= gap_d;
            count <= count_d;
            dots  <= dots_d;
        end
    end
endmodule

// File: tb/tb_braille_reader_ctrl.sv
// Directed bench for braille_reader_ctrl with DEPTH=4, DEB_CYCLES=4, BLANK_CYCLES=3.
module tb_braille_reader_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, start, clear, next_btn;
    logic [5:0] wr_data;
    logic       wr_ready, busy, done;
    logic [5:0] dots;
    logic [1:0] idx;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    braille_reader_ctrl #(.DEPTH(4), .DEB_CYCLES(4), .BLANK_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .clear(clear), .next_btn(next_btn),
        .dots(dots), .idx(idx), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [5:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step(1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Clean press: 4 cycles debounce + gap of 3 complete well inside 10 cycles.
    task automatic press();
        next_btn = 1'b1;
        step(10);
        next_btn = 1'b0;
        step(10);
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; start = 1'b0;
        clear = 1'b0; next_btn = 1'b0;
        step(2);
        check("rst_dots", dots, 0);
        check("rst_count", count, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_wr_ready", wr_ready, 1);
        rst_n = 1'b1;
        step(1);

        // Basic playback of three characters
        write(6'h01); write(6'h03); write(6'h09);
        check("load3_count", count, 3);
        pulse_start();
        check("show0", {busy, idx, dots}, {1'b1, 2'd0, 6'h01});
        press();
        check("show1", {idx, dots}, {2'd1, 6'h03});
        press();
        check("show2", {idx, dots}, {2'd2, 6'h09});
        press();
        check("done_state", {done, busy, dots}, {1'b1, 1'b0, 6'h00});
        press();
        check("done_ignores_next", {done, dots}, {1'b1, 6'h00});

        // Replay from DONE; buffer persisted; writes refused while playing
        pulse_start();
        check("replay", {busy, idx, dots}, {1'b1, 2'd0, 6'h01});
        wr_valid = 1'b1; wr_data = 6'h3f;
        step(1);
        wr_valid = 1'b0;
        check("play_no_write", {wr_ready, count}, {1'b0, 3'd3});

        // Bouncing button: no event while toggling every 2 cycles
        for (int i = 0; i < 10; i++) begin
            next_btn = ~next_btn;
            step(2);
        end
        check("bounce_no_evt", {idx, dots}, {2'd0, 6'h01});
        next_btn = 1'b1;
        step(6);
        check("deb_edge_still_show", {busy, dots}, {1'b1, 6'h01});
        step(1);
        check("deb_evt_blank", {busy, dots}, {1'b1, 6'h00});
        step(3);
        check("deb_adv", {idx, dots}, {2'd1, 6'h03});
        step(20);
        check("deb_single_evt", {idx, dots}, {2'd1, 6'h03});
        next_btn = 1'b0;
        step(10);

        // Clear during BLANK at idx=1
        next_btn = 1'b1;
        step(8);
        check("in_blank", {busy, idx, dots}, {1'b1, 2'd1, 6'h00});
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_blank", {busy, done, idx, count, dots}, 13'd0);
        check("clear_ready", wr_ready, 1);
        next_btn = 1'b0;
        step(10);

        // Write+start with empty buffer: write lands, start ignored
        wr_valid = 1'b1; wr_data = 6'h11; start = 1'b1;
        step(1);
        wr_valid = 1'b0; start = 1'b0;
        check("wrstart_empty", {busy, count}, {1'b0, 3'd1});
        write(6'h12); write(6'h13);
        // Write+start with data: both take effect, new char joins playback
        wr_valid = 1'b1; wr_data = 6'h14; start = 1'b1;
        step(1);
        wr_valid = 1'b0; start = 1'b0;
        check("wrstart_data", {busy, count, idx, dots}, {1'b1, 3'd4, 2'd0, 6'h11});
        press(); press();
        check("show_idx2", {idx, dots}, {2'd2, 6'h13});

        // Asynchronous reset mid-playback
        rst_n = 1'b0;
        #1;
        check("async_rst", {busy, done, idx, count, dots}, 13'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        pulse_start();
        check("start_empty_ignored", {busy, done}, 0);

        // Fill to capacity; fifth write refused
        write(6'h05); write(6'h06); write(6'h07); write(6'h08);
        check("full", {wr_ready, count}, {1'b0, 3'd4});
        write(6'h2a);
        check("full_no_wrap", count, 4);
        pulse_start();
        check("full_show0", dots, 6'h05);
        press(); press(); press();
        check("full_show3", {idx, dots}, {2'd3, 6'h08});
        press();
        check("full_done", {done, dots}, {1'b1, 6'h00});

        // Clear from DONE, then clear beats a same-cycle write
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_done", {done, count}, 0);
        wr_valid = 1'b1; wr_data = 6'h01; clear = 1'b1;
        step(1);
        wr_valid = 1'b0; clear = 1'b0;
        check("clear_beats_write", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
